// File: rtl/sine_taylor_pkg.sv
// sine_taylor_pkg: shared widths, default core latency and scheduler state encoding
package sine_taylor_pkg;
    localparam int ARG_W        = 12;
    localparam int RES_W        = 16;
    localparam int CORE_LAT_DEF = 4;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
endpackage

// File: rtl/sine_taylor_rr_arb.sv
// sine_taylor_rr_arb: combinational round-robin picker, first valid at or above rr_ptr_i with wrap
module sine_taylor_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_vld_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               any_o
);
    localparam logic [IDX_W:0] N = (IDX_W+1)'(NUM_REQ);
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    always_comb begin
        gnt_idx_o = '0;
        sum       = '0;
        idx       = '0;
        // scan from farthest to nearest so the closest valid requester wins
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr_i} + (IDX_W+1)'(i);
            idx = IDX_W'(sum >= N ? sum - N : sum);
            gnt_idx_o = req_vld_i[idx] ? idx : gnt_idx_o;
        end
        any_o = |req_vld_i;
        gnt_o = any_o ? NUM_REQ'(1) << gnt_idx_o : '0;
    end
endmodule

// File: rtl/sine_taylor_sched.sv
// sine_taylor_sched: round-robin sharing of one fixed-latency sine_taylor core among NUM_REQ requesters
module sine_taylor_sched
    import sine_taylor_pkg::*;
#(
    parameter int INT_BITS_I = ARG_W,
    parameter int INT_BITS_O = RES_W,
    parameter int NUM_REQ    = 4,
    parameter int CORE_LAT   = CORE_LAT_DEF
) (
    input  logic                          clk_i,
    input  logic                          srst_i,
    input  logic [NUM_REQ-1:0]            req_vld_i,
    input  logic [NUM_REQ*INT_BITS_I-1:0] req_x_i,
    output logic [NUM_REQ-1:0]            req_rdy_o,
    output logic [NUM_REQ-1:0]            rsp_vld_o,
    output logic [INT_BITS_O-1:0]         rsp_sinx_o,
    input  logic [NUM_REQ-1:0]            rsp_rdy_i,
    output logic [INT_BITS_I-1:0]         core_x_o,
    output logic                          core_arg_vld_o,
    input  logic [INT_BITS_O-1:0]         core_sinx_i,
    output logic                          busy_o
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int LAT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);

    state_e                  state_q;
    logic [IDX_W-1:0]        rr_ptr_q, gnt_q, gnt_idx;
    logic [NUM_REQ-1:0]      gnt;
    logic                    any_req;
    logic [INT_BITS_I-1:0]   x_q, x_sel;
    logic [INT_BITS_O-1:0]   res_q;
    logic [LAT_W-1:0]        lat_q;

    sine_taylor_rr_arb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req_vld_i (req_vld_i),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (any_req)
    );

    always_comb begin
        x_sel = '0;
        for (int i = 0; i < NUM_REQ; i++)
            x_sel = (gnt_idx == IDX_W'(i)) ? req_x_i[i*INT_BITS_I +: INT_BITS_I] : x_sel;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            x_q      <= '0;
            res_q    <= '0;
            lat_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (any_req) begin
                    x_q      <= x_sel;
                    gnt_q    <= gnt_idx;
                    rr_ptr_q <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
                    state_q  <= S_ISSUE;
                end
                S_ISSUE: begin
                    lat_q   <= LAT_W'(CORE_LAT - 1);
                    state_q <= S_WAIT;
                end
                // the core has no valid flag, so its output is trusted only when the count expires
                S_WAIT: if (lat_q == '0) begin
                    res_q   <= core_sinx_i;
                    state_q <= S_RESP;
                end else begin
                    lat_q <= lat_q - 1'b1;
                end
                S_RESP: if (rsp_rdy_i[gnt_q]) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_rdy_o      = (state_q == S_IDLE) ? gnt : '0;
    assign rsp_vld_o      = (state_q == S_RESP) ? NUM_REQ'(1) << gnt_q : '0;
    assign rsp_sinx_o     = res_q;
    assign core_x_o       = x_q;
    assign core_arg_vld_o = (state_q == S_ISSUE);
    assign busy_o         = (state_q != S_IDLE);
endmodule

// File: tb/tb_sine_taylor_sched.sv
// tb_sine_taylor_sched: table-driven, directed and random checks against a transaction-timing model
module tb_sine_taylor_sched;
    localparam int N = 4, LAT = 4, WI = 12, WO = 16;

    logic              clk_i = 1'b0, srst_i;
    logic [N-1:0]      req_vld_i, req_rdy_o, rsp_vld_o, rsp_rdy_i;
    logic [N*WI-1:0]   req_x_i;
    logic [WO-1:0]     rsp_sinx_o, core_sinx_i;
    logic [WI-1:0]     core_x_o;
    logic              core_arg_vld_o, busy_o;

    always #5 clk_i = ~clk_i;

    sine_taylor_sched #(.INT_BITS_I(WI), .INT_BITS_O(WO), .NUM_REQ(N), .CORE_LAT(LAT)) dut (
        .clk_i(clk_i), .srst_i(srst_i), .req_vld_i(req_vld_i), .req_x_i(req_x_i),
        .req_rdy_o(req_rdy_o), .rsp_vld_o(rsp_vld_o), .rsp_sinx_o(rsp_sinx_o),
        .rsp_rdy_i(rsp_rdy_i), .core_x_o(core_x_o), .core_arg_vld_o(core_arg_vld_o),
        .core_sinx_i(core_sinx_i), .busy_o(busy_o)
    );

    // core stand-in: {x,4'h0} exactly LAT cycles after arg_vld, odd garbage otherwise
    logic [LAT:1] cv = '0;
    logic [WI-1:0] cx [1:LAT];
    logic [WO-1:0] garb = 16'h0001;
    always @(posedge clk_i) begin
        for (int k = LAT; k > 1; k--) begin
            cv[k] <= cv[k-1];
            cx[k] <= cx[k-1];
        end
        cv[1] <= core_arg_vld_o;
        cx[1] <= core_x_o;
        garb  <= WO'($urandom()) | WO'(1);
    end
    assign core_sinx_i = cv[LAT] ? {cx[LAT], 4'h0} : garb;

    // model: ph = cycles since accept (-1 when idle)
    int ph, m_ptr, m_gnt, cyc, n_cmp, n_bad;
    logic [WI-1:0] m_x;
    logic [WO-1:0] m_res;
    logic [N-1:0]  last_rdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++)
            if (v[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    function automatic logic [N*WI-1:0] pk(input logic [WI-1:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic step(input logic rst, input logic [N-1:0] vld, input logic [N*WI-1:0] xs,
                        input logic [N-1:0] rr);
        int g;
        srst_i = rst; req_vld_i = vld; req_x_i = xs; rsp_rdy_i = rr;
        #1;
        g = (ph < 0) ? pick(vld, m_ptr) : -1;
        last_rdy = req_rdy_o;
        chk("req_rdy", req_rdy_o, g >= 0 ? 32'd1 << g : 32'd0);
        chk("arg_vld", core_arg_vld_o, 32'(ph == 1));
        chk("core_x", core_x_o, m_x);
        chk("rsp_vld", rsp_vld_o, ph >= LAT + 2 ? 32'd1 << m_gnt : 32'd0);
        chk("rsp_sinx", rsp_sinx_o, m_res);
        chk("busy", busy_o, 32'(ph >= 0));
        @(posedge clk_i);
        if (rst) begin
            ph = -1; m_ptr = 0; m_gnt = 0; m_x = '0; m_res = '0;
        end else if (g >= 0) begin
            ph = 1; m_x = xs[g*WI +: WI]; m_gnt = g; m_ptr = (g + 1) % N;
        end else if (ph >= 0) begin
            if (ph == LAT + 1) m_res = {m_x, 4'h0};
            if (ph >= LAT + 2 && rr[m_gnt]) ph = -1;
            else ph++;
        end
        cyc++;
        @(negedge clk_i);
    endtask

    typedef struct {
        int            req;
        logic [WI-1:0] x;
        logic [WO-1:0] exp;
    } vec_t;

    initial begin
        vec_t tbl[4];
        int acc_c[$], acc_g[$];
        int k;
        logic [N*WI-1:0] rr_x;
        n_cmp = 0; n_bad = 0; cyc = 0;
        srst_i = 1'b1; req_vld_i = '0; req_x_i = '0; rsp_rdy_i = '1;
        repeat (3) @(posedge clk_i);
        ph = -1; m_ptr = 0; m_gnt = 0; m_x = '0; m_res = '0;
        @(negedge clk_i);
        srst_i = 1'b0;
        #1;
        chk("reset_outs", {req_rdy_o, rsp_vld_o, rsp_sinx_o, core_x_o, core_arg_vld_o, busy_o}, '0);
        @(negedge clk_i);

        // single-request table: latency to rsp_vld and pass-through value
        tbl[0] = '{2, 12'h100, 16'h1000};
        tbl[1] = '{0, 12'hABC, 16'hABC0};
        tbl[2] = '{3, 12'hFFF, 16'hFFF0};
        tbl[3] = '{1, 12'h001, 16'h0010};
        foreach (tbl[i]) begin
            step(1'b0, N'(1) << tbl[i].req, pk(tbl[i].x, tbl[i].x, tbl[i].x, tbl[i].x), '1);
            chk("tbl_gnt", last_rdy, 32'd1 << tbl[i].req);
            for (k = 1; k <= 20; k++) begin
                if (rsp_vld_o != '0) break;
                step(1'b0, '0, '0, '1);
            end
            chk("tbl_lat", k, LAT + 2);
            chk("tbl_vld", rsp_vld_o, 32'd1 << tbl[i].req);
            chk("tbl_sinx", rsp_sinx_o, tbl[i].exp);
            step(1'b0, '0, '0, '1);
        end

        // round-robin: all valid continuously
        step(1'b1, '0, '0, '1);
        rr_x = pk(12'h011, 12'h022, 12'h033, 12'h044);
        for (int c = 0; c < 30; c++) begin
            step(1'b0, '1, rr_x, '1);
            for (int j = 0; j < N; j++)
                if (last_rdy[j]) begin acc_c.push_back(c); acc_g.push_back(j); end
        end
        chk("rr_count", acc_g.size(), 5);
        for (int i = 0; i < acc_g.size() && i < 5; i++) chk("rr_order", acc_g[i], i % N);
        for (int i = 1; i < acc_c.size() && i < 5; i++) chk("rr_space", acc_c[i] - acc_c[i-1], LAT + 3);

        // pointer wrap: serve 3, then 1 and 3 valid
        step(1'b1, '0, '0, '1);
        step(1'b0, 4'b1000, rr_x, '1);
        repeat (LAT + 2) step(1'b0, '0, rr_x, '1);
        step(1'b0, 4'b1010, rr_x, '1);
        chk("wrap_first", last_rdy, 4'b0010);
        repeat (LAT + 2) step(1'b0, 4'b1010, rr_x, '1);
        step(1'b0, 4'b1010, rr_x, '1);
        chk("wrap_second", last_rdy, 4'b1000);
        repeat (LAT + 2) step(1'b0, '0, rr_x, '1);

        // back-pressure with requester 2 pending
        step(1'b1, '0, '0, '1);
        step(1'b0, 4'b0001, rr_x, '0);
        repeat (LAT + 1) step(1'b0, 4'b0100, rr_x, '0);
        repeat (10) begin
            step(1'b0, 4'b0100, rr_x, '0);
            chk("bp_vld", rsp_vld_o, 4'b0001);
            chk("bp_sinx", rsp_sinx_o, 16'h0110);
        end
        step(1'b0, 4'b0100, rr_x, 4'b0001);
        step(1'b0, 4'b0100, rr_x, '1);
        chk("bp_next", last_rdy, 4'b0100);
        repeat (LAT + 2) step(1'b0, '0, rr_x, '1);

        // wrong-ready: requester 1 in RESP sees 1101
        step(1'b1, '0, '0, '1);
        step(1'b0, 4'b0010, rr_x, 4'b1101);
        repeat (LAT + 6) step(1'b0, '0, rr_x, 4'b1101);
        chk("wr_busy", busy_o, 1);
        chk("wr_vld", rsp_vld_o, 4'b0010);
        step(1'b0, '0, rr_x, 4'b0010);
        chk("wr_done", busy_o, 0);

        // reset two cycles after ISSUE
        step(1'b0, 4'b0100, rr_x, '1);
        step(1'b0, '0, rr_x, '1);
        step(1'b0, '0, rr_x, '1);
        step(1'b1, '0, rr_x, '1);
        chk("rst_outs", {req_rdy_o, rsp_vld_o, rsp_sinx_o, core_x_o, core_arg_vld_o, busy_o}, '0);
        repeat (LAT + 4) step(1'b0, '0, rr_x, '1);
        step(1'b0, 4'b1010, rr_x, '1);
        chk("rst_ptr", last_rdy, 4'b0010);
        repeat (LAT + 2) step(1'b0, '0, rr_x, '1);

        // random traffic, model checks every cycle
        for (int c = 0; c < 400; c++)
            step($urandom_range(0, 99) == 0, N'($urandom()), (N*WI)'({$urandom(), $urandom()}),
                 ($urandom_range(0, 2) == 0) ? N'($urandom()) : '1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
